add8_sched: RTL and testbench

Round-robin scheduler that shares one external 8-bit carry-select adder (csa8) between up to eight requesters. Each requester issues multi-byte add operations (a + b + cin). The block serialises each operation byte-by-byte through the shared adder, chaining the carry, and returns the full-width sum and carry-out with the requester ID. It sits between the multiplier's partial-product/accumulate clients and the single csa8 instance, trading latency for adder area.

---
 rtl/add8_sched.sv | 172 +++++++++++++++++
 tb/tb_add8_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_sched.sv
// Round-robin scheduler that time-shares one external 8-bit adder across N_REQ requesters.
// Each operation is fed through the adder one byte per cycle, LSB first, with the carry chained in a register.
module add8_sched #(
  parameter int N_REQ    = 4,
  parameter int OP_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*8*OP_BYTES-1:0]  req_a,
  input  logic [N_REQ*8*OP_BYTES-1:0]  req_b,
  input  logic [N_REQ-1:0]             req_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2:0]                   rsp_id,
  output logic [8*OP_BYTES-1:0]        rsp_sum,
  output logic                         rsp_cout,
  output logic [7:0]                   add_a,
  output logic [7:0]                   add_b,
  output logic                         add_cin,
  input  logic [7:0]                   add_sum,
  input  logic                         add_cout,
  output logic                         busy
);
  localparam int W  = 8 * OP_BYTES;
  localparam int IW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [2:0]      id_q, id_d;

  logic [7:0]      valid_pad_s, ready_pad_s;
  logic [3:0]      cand_s;
  logic            take_s, found_s;
  logic [2:0]      grant_s;
  logic [W-1:0]    sel_a_s, sel_b_s;
  logic            sel_cin_s;
  logic [7:0]      byte_a_s, byte_b_s;

  // Search from ptr upward (wrapping at N_REQ) for the first valid requester.
  always_comb begin
    valid_pad_s                = 8'd0;
    valid_pad_s[N_REQ-1:0]     = req_valid;
    cand_s                     = 4'd0;
    take_s                     = 1'b0;
    found_s                    = 1'b0;
    grant_s                    = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s  = {1'b0, ptr_q} + 4'(k);
      cand_s  = (cand_s >= 4'(N_REQ)) ? cand_s - 4'(N_REQ) : cand_s;
      take_s  = !found_s && valid_pad_s[cand_s[2:0]];
      grant_s = take_s ? cand_s[2:0] : grant_s;
      found_s = found_s | take_s;
    end
  end

  // Pick the winner's operands out of the packed request buses.
  always_comb begin
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_cin_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s   = (grant_s == 3'(i)) ? req_a[i*W +: W] : sel_a_s;
      sel_b_s   = (grant_s == 3'(i)) ? req_b[i*W +: W] : sel_b_s;
      sel_cin_s = (grant_s == 3'(i)) ? req_cin[i]      : sel_cin_s;
    end
  end

  // Select the operand byte currently being added.
  always_comb begin
    byte_a_s = 8'd0;
    byte_b_s = 8'd0;
    for (int j = 0; j < OP_BYTES; j++) begin
      byte_a_s = (idx_q == IW'(j)) ? a_q[j*8 +: 8] : byte_a_s;
      byte_b_s = (idx_q == IW'(j)) ? b_q[j*8 +: 8] : byte_b_s;
    end
  end

  // Next-state, datapath updates and adder drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    id_d        = id_q;
    ready_pad_s = 8'd0;
    add_a       = 8'd0;
    add_b       = 8'd0;
    add_cin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          ready_pad_s = 8'd1 << grant_s;
          a_d         = sel_a_s;
          b_d         = sel_b_s;
          carry_d     = sel_cin_s;
          id_d        = grant_s;
          idx_d       = '0;
          ptr_d       = (grant_s == 3'(N_REQ - 1)) ? 3'd0 : grant_s + 3'd1;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        add_a   = byte_a_s;
        add_b   = byte_b_s;
        add_cin = carry_q;
        carry_d = add_cout;
        for (int j = 0; j < OP_BYTES; j++) begin
          sum_d[j*8 +: 8] = (idx_q == IW'(j)) ? add_sum : sum_q[j*8 +: 8];
        end
        if (idx_q == IW'(OP_BYTES - 1)) begin
          idx_d   = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  // Gating with rst_n keeps req_ready low while reset is asserted.
  assign req_ready = ready_pad_s[N_REQ-1:0] & {N_REQ{rst_n}};
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_add8_sched.sv
// Directed and random checks of add8_sched with a behavioural csa8 model.
module tb_add8_sched;
  localparam int NR = 4, W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_cin;
  logic [NR*W-1:0]   req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_cout, add_cin, add_cout, busy;
  logic [2:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic [7:0]        add_a, add_b, add_sum;
  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  add8_sched #(.N_REQ(NR), .OP_BYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .add_cout(add_cout), .busy(busy));

  // One-byte operands, two requesters
  logic [1:0]  r1_valid, r1_ready, r1_cin;
  logic [15:0] r1_a, r1_b;
  logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_cout, r1_add_cin, r1_add_cout, r1_busy;
  logic [2:0]  r1_rsp_id;
  logic [7:0]  r1_rsp_sum, r1_add_a, r1_add_b, r1_add_sum;
  assign {r1_add_cout, r1_add_sum} = 9'(r1_add_a) + 9'(r1_add_b) + 9'(r1_add_cin);

  add8_sched #(.N_REQ(2), .OP_BYTES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_a(r1_a), .req_b(r1_b), .req_cin(r1_cin), .rsp_valid(r1_rsp_valid),
    .rsp_ready(r1_rsp_ready), .rsp_id(r1_rsp_id), .rsp_sum(r1_rsp_sum), .rsp_cout(r1_rsp_cout),
    .add_a(r1_add_a), .add_b(r1_add_b), .add_cin(r1_add_cin), .add_sum(r1_add_sum),
    .add_cout(r1_add_cout), .busy(r1_busy));

  // Four-byte operands, three requesters
  logic [2:0]  r4_valid, r4_ready, r4_cin;
  logic [95:0] r4_a, r4_b;
  logic        r4_rsp_valid, r4_rsp_ready, r4_rsp_cout, r4_add_cin, r4_add_cout, r4_busy;
  logic [2:0]  r4_rsp_id;
  logic [31:0] r4_rsp_sum;
  logic [7:0]  r4_add_a, r4_add_b, r4_add_sum;
  assign {r4_add_cout, r4_add_sum} = 9'(r4_add_a) + 9'(r4_add_b) + 9'(r4_add_cin);

  add8_sched #(.N_REQ(3), .OP_BYTES(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .req_valid(r4_valid), .req_ready(r4_ready),
    .req_a(r4_a), .req_b(r4_b), .req_cin(r4_cin), .rsp_valid(r4_rsp_valid),
    .rsp_ready(r4_rsp_ready), .rsp_id(r4_rsp_id), .rsp_sum(r4_rsp_sum), .rsp_cout(r4_rsp_cout),
    .add_a(r4_add_a), .add_b(r4_add_b), .add_cin(r4_add_cin), .add_sum(r4_add_sum),
    .add_cout(r4_add_cout), .busy(r4_busy));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the 2-byte instance; rsp_ready randomised when rnd is set.
  task automatic op_main(input int id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input bit rnd);
    bit done = 1'b0;
    logic [15:0] got_sum = '0;
    logic got_cout = 1'b0;
    logic [2:0] got_id = '0;
    @(posedge clk); #1;
    req_a[id*W +: W] = a; req_b[id*W +: W] = b; req_cin[id] = cin; req_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = req_ready[id];
    end
    chk("m_accept", 64'(done), 64'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        done = 1'b1; got_sum = rsp_sum; got_cout = rsp_cout; got_id = rsp_id;
      end
      @(posedge clk); #1;
    end
    chk("m_rsp_seen", 64'(done), 64'd1);
    chk("m_sum", 64'({got_cout, got_sum}), 64'({ec, es}));
    chk("m_id", 64'(got_id), 64'(id));
  endtask

  task automatic op_w1(input int id, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bit done = 1'b0;
    logic [8:0] got = '0;
    logic [2:0] got_id = '0;
    @(posedge clk); #1;
    r1_a[id*8 +: 8] = a; r1_b[id*8 +: 8] = b; r1_cin[id] = cin; r1_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = r1_ready[id];
    end
    chk("w1_accept", 64'(done), 64'd1);
    @(posedge clk); #1;
    r1_valid[id] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      r1_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (r1_rsp_valid && r1_rsp_ready) begin
        done = 1'b1; got = {r1_rsp_cout, r1_rsp_sum}; got_id = r1_rsp_id;
      end
      @(posedge clk); #1;
    end
    chk("w1_rsp_seen", 64'(done), 64'd1);
    chk("w1_sum", 64'(got), 64'(9'(a) + 9'(b) + 9'(cin)));
    chk("w1_id", 64'(got_id), 64'(id));
  endtask

  task automatic op_w4(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
    bit done = 1'b0;
    logic [32:0] got = '0;
    logic [2:0] got_id = '0;
    @(posedge clk); #1;
    r4_a[id*32 +: 32] = a; r4_b[id*32 +: 32] = b; r4_cin[id] = cin; r4_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = r4_ready[id];
    end
    chk("w4_accept", 64'(done), 64'd1);
    @(posedge clk); #1;
    r4_valid[id] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      r4_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (r4_rsp_valid && r4_rsp_ready) begin
        done = 1'b1; got = {r4_rsp_cout, r4_rsp_sum}; got_id = r4_rsp_id;
      end
      @(posedge clk); #1;
    end
    chk("w4_rsp_seen", 64'(done), 64'd1);
    chk("w4_sum", 64'(got), 64'(33'(a) + 33'(b) + 33'(cin)));
    chk("w4_id", 64'(got_id), 64'(id));
  endtask

  int exp_ids [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};

  initial begin
    int g;
    logic [16:0] e17;
    logic [15:0] ra, rb;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_cin = '0; req_a = '0; req_b = '0;
    r1_valid = '0; r1_cin = '0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b1;
    r4_valid = '0; r4_cin = '0; r4_a = '0; r4_b = '0; r4_rsp_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    chk("rst_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'd0);
    chk("rst_others", 64'({r1_busy, r4_busy, r1_rsp_valid, r4_rsp_valid}), 64'd0);
    #9 rst_n = 1'b1;

    // Single op, requester 0: 00FF + 0001
    @(posedge clk); #1;
    req_a[15:0] = 16'h00FF; req_b[15:0] = 16'h0001; req_cin[0] = 1'b0; req_valid = 4'b0001;
    @(negedge clk);
    chk("s_ready", 64'(req_ready), 64'b0001);
    chk("s_busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("s_busy_run", 64'(busy), 64'd1);
    chk("s_byte0", 64'({add_a, add_b, add_cin}), 64'({8'hFF, 8'h01, 1'b0}));
    chk("s_rv_run0", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("s_byte1", 64'({add_a, add_b, add_cin}), 64'({8'h00, 8'h00, 1'b1}));
    chk("s_rv_run1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("s_rv", 64'(rsp_valid), 64'd1);
    chk("s_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({3'd0, 1'b0, 16'h0100}));
    chk("s_add_resp", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    chk("s_idle", 64'({busy, rsp_valid}), 64'd0);

    // Carry edge cases
    op_main(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_main(2, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0);
    op_main(3, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Fairness: all valid from reset, requester 2 leaves after six grants
    rst_n = 1'b0; req_valid = 4'b1111;
    #3 rst_n = 1'b1;
    g = 0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      @(negedge clk);
      chk("f_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (req_ready != 4'b0000) begin
        chk("f_order", 64'(req_ready), 64'(4'b0001 << exp_ids[g]));
        g++;
        if (g == 6) req_valid[2] = 1'b0;
      end
    end
    chk("f_count", 64'(g), 64'd10);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: requester 1, 1234 + 4321 + 1, ptr now 0 and only 1 valid
    rsp_ready = 1'b0;
    req_a[31:16] = 16'h1234; req_b[31:16] = 16'h4321; req_cin[1] = 1'b1; req_valid = 4'b0010;
    @(negedge clk);
    chk("b_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1101;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("b_hold_rv", 64'(rsp_valid), 64'd1);
      chk("b_hold_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({3'd1, 1'b0, 16'h5556}));
      chk("b_hold_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b_still_resp", 64'({busy, rsp_valid}), 64'b11);
    chk("b_no_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("b_back_idle", 64'({busy, rsp_valid}), 64'b00);
    chk("b_next_grant", 64'(req_ready), 64'b0100);
    req_valid = 4'b0000;

    // Reset mid-RUN: ptr is 2, so requester 2 is accepted then discarded
    @(posedge clk); #1;
    req_a[47:32] = 16'h0101; req_b[47:32] = 16'h0202; req_cin[2] = 1'b1; req_valid = 4'b0100;
    @(negedge clk);
    chk("r_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #2;
    chk("r_busy_run", 64'(busy), 64'd1);
    chk("r_add_run", 64'({add_a, add_b, add_cin}), 64'({8'h01, 8'h02, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("r_async", 64'({busy, rsp_valid, add_a, add_b, add_cin}), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r_no_rsp", 64'({busy, rsp_valid}), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("r_ptr0", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    chk("r_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_sum}), 64'({1'b1, 3'd0, 1'b0, 16'h0100}));
    @(posedge clk); #1;

    // Random operations on all three widths
    for (int n = 0; n < 400; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      g = int'($urandom_range(0, 3));
      e17 = 17'(ra) + 17'(rb) + 17'(n[0]);
      op_main(g, ra, rb, n[0], e17[15:0], e17[16], 1'b1);
    end
    rsp_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op_w1(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int n = 0; n < 300; n++) begin
      op_w4(int'($urandom_range(0, 2)), $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
